id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: freeze  in  1  memory-stall hold; flush  in  1  taken-branch squash; id_valid  in  1  ID holds a real instruction.
REQ-003 SHALL have: id_pc  in  32; reg1, reg2  in  32  register-file read data; src1, src2, dest  in  5; imm  in  32  sign-extended immediate.
REQ-004 SHALL have: exe_cmd  in  4; mem_r_en, mem_w_en, wb_en, is_imm, uses_src2  in  1 each.
REQ-005 SHALL have forwarding inputs: mem_dest  in  5, mem_wb_en  in  1, mem_result  in  32; wb_dest  in  5, wb_wb_en  in  1, wb_value  in  32.
REQ-006 SHALL have outputs: ex_valid  1; ex_pc  32; ex_val1  32; ex_val2  32; ex_st_val  32; ex_dest  5; ex_cmd  4; ex_mem_r_en, ex_mem_w_en, ex_wb_en  1 each.
REQ-007 SHALL have outputs: stall_out  1  combinational, holds IF/ID; stall_count  16  load-use stall counter.

Function
REQ-008 SHALL form fwd1: mem_result if mem_wb_en and mem_dest!=0 and mem_dest==src1; else wb_value if wb_wb_en and wb_dest!=0 and wb_dest==src1; else reg1.
REQ-009 SHALL form fwd2 identically from src2/reg2; MEM priority over WB; register 0 never forwarded.
REQ-010 SHALL assert hazard when ex_valid and ex_mem_r_en and ex_wb_en and ex_dest!=0 and id_valid and (src1==ex_dest or (uses_src2 and src2==ex_dest)).
REQ-011 SHALL drive stall_out = hazard and not flush, combinationally, independent of freeze.
REQ-012 SHALL apply per rising edge, in priority: freeze > flush > hazard > id_valid==0 > load.
REQ-013 freeze=1: all registered outputs and stall_count SHALL hold.
REQ-014 flush=1 or hazard or id_valid=0: SHALL load a bubble; ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_cmd cleared; other fields hold.
REQ-015 Load: ex_valid=1; ex_pc=id_pc; ex_val1=fwd1; ex_val2=is_imm?imm:fwd2; ex_st_val=fwd2; ex_dest, ex_cmd, enables copied from ID.
REQ-016 ex_wb_en SHALL load 0 when dest==0 (R0 writes suppressed).
REQ-017 stall_count SHALL increment on each edge with hazard, not freeze, not flush; saturates at 16'hFFFF, no wrap.
REQ-018 Hazard and flush same cycle: flush wins, bubble loaded, stall_out=0, no count.
REQ-019 A hazard SHALL last exactly one cycle per load-use pair, since the bubble clears ex_mem_r_en.
REQ-020 Forwarding SHALL use only the current cycle's mem_*/wb_* inputs; no internal forwarding state.

Reset
REQ-021 rst=1 SHALL immediately, without clk, clear every registered output and stall_count to 0.
REQ-022 Reset mid-operation SHALL discard the in-flight instruction; first edge after release follows REQ-012.
REQ-023 stall_out SHALL read 0 during reset, since ex_valid=0.

Verification
REQ-024 Load src1=3 with reg1=0x10, no forwarding -> ex_val1=0x10, ex_valid=1 next edge.
REQ-025 src1=5, mem_dest=5, mem_wb_en=1, mem_result=0xAA, wb_dest=5, wb_value=0xBB -> ex_val1=0xAA; repeat with mem_dest=0 -> ex_val1=0xBB.
REQ-026 ex stage holds lw to r7; ID has add using r7 as src2, uses_src2=1 -> stall_out=1, bubble next edge, stall_count=1; following edge loads add.
REQ-027 Hazard and flush together -> stall_out=0, bubble, stall_count unchanged.
REQ-028 freeze=1 for 3 cycles with changing ID inputs -> all outputs constant; stall_count preloaded 0xFFFF with hazard -> stays 0xFFFF.
REQ-029 Assert rst between clock edges with ex_valid=1 -> all outputs 0 before next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with MEM/WB operand forwarding,
//                load-use hazard detection and a saturating stall counter.
//  Revision    : 1.0
// ============================================================================
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [4:0]  dest,
    input  logic [31:0] imm,
    input  logic [3:0]  exe_cmd,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        wb_en,
    input  logic        is_imm,
    input  logic        uses_src2,
    input  logic [4:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_dest,
    input  logic        wb_wb_en,
    input  logic [31:0] wb_value,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [31:0] ex_st_val,
    output logic [4:0]  ex_dest,
    output logic [3:0]  ex_cmd,
    output logic        ex_mem_r_en,
    output logic        ex_mem_w_en,
    output logic        ex_wb_en,
    output logic        stall_out,
    output logic [15:0] stall_count
);

    localparam logic [4:0]  c_R0      = 5'd0;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_val1;
    logic [31:0] r_val2;
    logic [31:0] r_st_val;
    logic [4:0]  r_dest;
    logic [3:0]  r_cmd;
    logic        r_mem_r_en;
    logic        r_mem_w_en;
    logic        r_wb_en;
    logic [15:0] r_stall_count;

    logic [31:0] w_fwd1;
    logic [31:0] w_fwd2;
    logic        w_hazard;
    logic        w_bubble;

    // MEM stage is younger than WB, so its result takes priority.
    always_comb begin
        w_fwd1 = reg1;
        if (mem_wb_en && (mem_dest != c_R0) && (mem_dest == src1))
            w_fwd1 = mem_result;
        else if (wb_wb_en && (wb_dest != c_R0) && (wb_dest == src1))
            w_fwd1 = wb_value;
    end

    always_comb begin
        w_fwd2 = reg2;
        if (mem_wb_en && (mem_dest != c_R0) && (mem_dest == src2))
            w_fwd2 = mem_result;
        else if (wb_wb_en && (wb_dest != c_R0) && (wb_dest == src2))
            w_fwd2 = wb_value;
    end

    assign w_hazard = r_valid && r_mem_r_en && r_wb_en && (r_dest != c_R0) && id_valid &&
                      ((src1 == r_dest) || (uses_src2 && (src2 == r_dest)));
    assign w_bubble = flush || w_hazard || !id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_pc          <= 32'd0;
            r_val1        <= 32'd0;
            r_val2        <= 32'd0;
            r_st_val      <= 32'd0;
            r_dest        <= 5'd0;
            r_cmd         <= 4'd0;
            r_mem_r_en    <= 1'b0;
            r_mem_w_en    <= 1'b0;
            r_wb_en       <= 1'b0;
            r_stall_count <= 16'd0;
        end else if (!freeze) begin
            if (w_hazard && !flush && (r_stall_count != c_CNT_MAX))
                r_stall_count <= r_stall_count + 16'd1;

            // A bubble only kills the control fields; datapath fields keep their value.
            if (w_bubble) begin
                r_valid    <= 1'b0;
                r_cmd      <= 4'd0;
                r_mem_r_en <= 1'b0;
                r_mem_w_en <= 1'b0;
                r_wb_en    <= 1'b0;
            end else begin
                r_valid    <= 1'b1;
                r_pc       <= id_pc;
                r_val1     <= w_fwd1;
                r_val2     <= is_imm ? imm : w_fwd2;
                r_st_val   <= w_fwd2;
                r_dest     <= dest;
                r_cmd      <= exe_cmd;
                r_mem_r_en <= mem_r_en;
                r_mem_w_en <= mem_w_en;
                r_wb_en    <= wb_en && (dest != c_R0);
            end
        end
    end

    assign stall_out   = w_hazard && !flush;
    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_val1     = r_val1;
    assign ex_val2     = r_val2;
    assign ex_st_val   = r_st_val;
    assign ex_dest     = r_dest;
    assign ex_cmd      = r_cmd;
    assign ex_mem_r_en = r_mem_r_en;
    assign ex_mem_w_en = r_mem_w_en;
    assign ex_wb_en    = r_wb_en;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage (vector table plus
//                hand-written hazard/freeze/reset sequences).
//  Revision    : 1.0
// ============================================================================
module tb_id_ex_stage;

    typedef struct packed {
        logic        flush;
        logic        idv;
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        is_imm;
        logic        us2;
        logic [4:0]  mdst;
        logic        mwb;
        logic [31:0] mres;
        logic [4:0]  wdst;
        logic        wwb;
        logic [31:0] wval;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] st;
        logic [4:0]  dest;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, id_valid;
    logic [31:0] id_pc, reg1, reg2, imm, mem_result, wb_value;
    logic [4:0]  src1, src2, dest, mem_dest, wb_dest;
    logic [3:0]  exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en, is_imm, uses_src2, mem_wb_en, wb_wb_en;
    logic        ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en, stall_out;
    logic [31:0] ex_pc, ex_val1, ex_val2, ex_st_val;
    logic [4:0]  ex_dest;
    logic [3:0]  ex_cmd;
    logic [15:0] stall_count;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .reg1(reg1), .reg2(reg2), .src1(src1), .src2(src2), .dest(dest),
        .imm(imm), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .is_imm(is_imm), .uses_src2(uses_src2),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_result(mem_result),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .wb_value(wb_value),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val1(ex_val1), .ex_val2(ex_val2),
        .ex_st_val(ex_st_val), .ex_dest(ex_dest), .ex_cmd(ex_cmd),
        .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en), .ex_wb_en(ex_wb_en),
        .stall_out(stall_out), .stall_count(stall_count)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic apply(input in_t v);
        flush      = v.flush;   id_valid  = v.idv;    id_pc     = v.pc;
        reg1       = v.reg1;    reg2      = v.reg2;   src1      = v.src1;
        src2       = v.src2;    dest      = v.dest;   imm       = v.imm;
        exe_cmd    = v.cmd;     mem_r_en  = v.mr;     mem_w_en  = v.mw;
        wb_en      = v.wb;      is_imm    = v.is_imm; uses_src2 = v.us2;
        mem_dest   = v.mdst;    mem_wb_en = v.mwb;    mem_result = v.mres;
        wb_dest    = v.wdst;    wb_wb_en  = v.wwb;    wb_value  = v.wval;
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, got none expected one entry", name);
        end else begin
            tests--;
            e = exp_q.pop_front();
            cmp({name, ".valid"}, 32'(ex_valid),    32'(e.valid));
            cmp({name, ".pc"},    ex_pc,            e.pc);
            cmp({name, ".val1"},  ex_val1,          e.val1);
            cmp({name, ".val2"},  ex_val2,          e.val2);
            cmp({name, ".st"},    ex_st_val,        e.st);
            cmp({name, ".dest"},  32'(ex_dest),     32'(e.dest));
            cmp({name, ".cmd"},   32'(ex_cmd),      32'(e.cmd));
            cmp({name, ".mr"},    32'(ex_mem_r_en), 32'(e.mr));
            cmp({name, ".mw"},    32'(ex_mem_w_en), 32'(e.mw));
            cmp({name, ".wb"},    32'(ex_wb_en),    32'(e.wb));
            cmp({name, ".cnt"},   32'(stall_count), 32'(e.cnt));
        end
    endtask

    // Push the expectation now, compare it just after the next rising edge.
    task automatic step(input string name, input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_pop(name);
    endtask

    task automatic chk_zero(input string name);
        exp_t z;
        z = '0;
        exp_q.push_back(z);
        check_pop(name);
        cmp({name, ".stall"}, 32'(stall_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t   vin[8];
        exp_t  vexp[8];
        string names[8];
        in_t   v;

        names[0] = "basic";
        vin[0]   = '{0,1,32'h100,32'h10,32'h20,5'd3,5'd4,5'd8,32'h5,4'd2,0,0,1,0,1, 5'd0,0,32'h0, 5'd0,0,32'h0};
        vexp[0]  = '{1,32'h100,32'h10,32'h20,32'h20,5'd8,4'd2,0,0,1,16'd0};
        names[1] = "fwd_mem_pri";
        vin[1]   = '{0,1,32'h104,32'h11,32'h22,5'd5,5'd6,5'd9,32'h0,4'd3,0,0,1,0,1, 5'd5,1,32'hAA, 5'd5,1,32'hBB};
        vexp[1]  = '{1,32'h104,32'hAA,32'h22,32'h22,5'd9,4'd3,0,0,1,16'd0};
        names[2] = "fwd_wb";
        vin[2]   = '{0,1,32'h108,32'h11,32'h22,5'd5,5'd6,5'd9,32'h0,4'd3,0,0,1,0,1, 5'd0,1,32'hAA, 5'd5,1,32'hBB};
        vexp[2]  = '{1,32'h108,32'hBB,32'h22,32'h22,5'd9,4'd3,0,0,1,16'd0};
        names[3] = "fwd_src2_imm";
        vin[3]   = '{0,1,32'h10C,32'h1,32'h2,5'd1,5'd7,5'd10,32'hFFFFFFF0,4'd4,0,0,1,1,1, 5'd7,1,32'h77, 5'd0,0,32'h0};
        vexp[3]  = '{1,32'h10C,32'h1,32'hFFFFFFF0,32'h77,5'd10,4'd4,0,0,1,16'd0};
        names[4] = "r0_store";
        vin[4]   = '{0,1,32'h110,32'h33,32'h44,5'd0,5'd0,5'd0,32'h0,4'd5,0,1,1,0,1, 5'd0,1,32'hDEAD, 5'd0,1,32'hBEEF};
        vexp[4]  = '{1,32'h110,32'h33,32'h44,32'h44,5'd0,4'd5,0,1,0,16'd0};
        names[5] = "mem_wb_off";
        vin[5]   = '{0,1,32'h114,32'h99,32'h66,5'd2,5'd3,5'd11,32'h0,4'd6,0,0,0,0,1, 5'd2,0,32'h12, 5'd2,1,32'h55};
        vexp[5]  = '{1,32'h114,32'h55,32'h66,32'h66,5'd11,4'd6,0,0,0,16'd0};
        names[6] = "invalid";
        vin[6]   = '{0,0,32'h200,32'h1,32'h2,5'd1,5'd2,5'd13,32'h0,4'd7,1,1,1,0,1, 5'd0,0,32'h0, 5'd0,0,32'h0};
        vexp[6]  = '{0,32'h114,32'h55,32'h66,32'h66,5'd11,4'd0,0,0,0,16'd0};
        names[7] = "flush";
        vin[7]   = '{1,1,32'h204,32'h1,32'h2,5'd1,5'd2,5'd13,32'h0,4'd7,0,1,1,0,1, 5'd0,0,32'h0, 5'd0,0,32'h0};
        vexp[7]  = '{0,32'h114,32'h55,32'h66,32'h66,5'd11,4'd0,0,0,0,16'd0};

        rst = 1'b1;
        freeze = 1'b0;
        v = '0;
        apply(v);
        #3 chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(vin[i]);
            #1 cmp({names[i], ".stall"}, 32'(stall_out), 32'd0);
            step(names[i], vexp[i]);
        end

        // Load-use on src2: one bubble, counter 1, then the consumer loads.
        @(negedge clk);
        v = '0; v.idv = 1; v.pc = 32'h300; v.reg1 = 32'h1000; v.src1 = 5'd1; v.dest = 5'd7;
        v.imm = 32'h4; v.cmd = 4'd1; v.mr = 1; v.wb = 1; v.is_imm = 1;
        apply(v);
        step("lw1", '{1,32'h300,32'h1000,32'h4,32'h0,5'd7,4'd1,1,0,1,16'd0});
        @(negedge clk);
        v = '0; v.idv = 1; v.pc = 32'h304; v.reg1 = 32'h2; v.reg2 = 32'h3; v.src1 = 5'd2;
        v.src2 = 5'd7; v.us2 = 1; v.dest = 5'd12; v.cmd = 4'd2; v.wb = 1;
        apply(v);
        #1 cmp("lu.stall", 32'(stall_out), 32'd1);
        step("lu_bubble", '{0,32'h300,32'h1000,32'h4,32'h0,5'd7,4'd0,0,0,0,16'd1});
        cmp("lu.stall_clear", 32'(stall_out), 32'd0);
        step("lu_add", '{1,32'h304,32'h2,32'h3,32'h3,5'd12,4'd2,0,0,1,16'd1});

        // Hazard coinciding with flush: flush wins, no count.
        @(negedge clk);
        v = '0; v.idv = 1; v.pc = 32'h308; v.reg1 = 32'h2000; v.src1 = 5'd1; v.dest = 5'd7;
        v.imm = 32'h8; v.cmd = 4'd1; v.mr = 1; v.wb = 1; v.is_imm = 1;
        apply(v);
        step("lw2", '{1,32'h308,32'h2000,32'h8,32'h0,5'd7,4'd1,1,0,1,16'd1});
        @(negedge clk);
        v = '0; v.flush = 1; v.idv = 1; v.pc = 32'h30C; v.src1 = 5'd7; v.dest = 5'd12;
        v.cmd = 4'd2; v.wb = 1;
        apply(v);
        #1 cmp("hf.stall", 32'(stall_out), 32'd0);
        step("hf_bubble", '{0,32'h308,32'h2000,32'h8,32'h0,5'd7,4'd0,0,0,0,16'd1});

        // Freeze for three cycles while a hazard is pending.
        @(negedge clk);
        v = '0; v.idv = 1; v.pc = 32'h310; v.reg1 = 32'h3000; v.src1 = 5'd1; v.dest = 5'd7;
        v.imm = 32'hC; v.cmd = 4'd1; v.mr = 1; v.wb = 1; v.is_imm = 1;
        apply(v);
        step("lw3", '{1,32'h310,32'h3000,32'hC,32'h0,5'd7,4'd1,1,0,1,16'd1});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            freeze = 1'b1;
            v = '0; v.idv = 1; v.pc = 32'h314 + 32'(4 * k); v.reg1 = 32'h5 + 32'(k);
            v.src1 = 5'd7; v.dest = 5'd13; v.cmd = 4'd3; v.wb = 1;
            apply(v);
            #1 cmp("frz.stall", 32'(stall_out), 32'd1);
            step("frz_hold", '{1,32'h310,32'h3000,32'hC,32'h0,5'd7,4'd1,1,0,1,16'd1});
        end
        @(negedge clk);
        freeze = 1'b0;
        step("frz_release", '{0,32'h310,32'h3000,32'hC,32'h0,5'd7,4'd0,0,0,0,16'd2});

        // Saturation of the stall counter.
        @(negedge clk);
        v = '0; v.idv = 1; v.pc = 32'h320; v.reg1 = 32'h4000; v.src1 = 5'd1; v.dest = 5'd7;
        v.imm = 32'h10; v.cmd = 4'd1; v.mr = 1; v.wb = 1; v.is_imm = 1;
        apply(v);
        step("lw4", '{1,32'h320,32'h4000,32'h10,32'h0,5'd7,4'd1,1,0,1,16'd2});
        @(negedge clk);
        force dut.r_stall_count = 16'hFFFE;
        #1 release dut.r_stall_count;
        v = '0; v.idv = 1; v.pc = 32'h324; v.src1 = 5'd7; v.dest = 5'd14; v.cmd = 4'd2; v.wb = 1;
        apply(v);
        step("sat_reach", '{0,32'h320,32'h4000,32'h10,32'h0,5'd7,4'd0,0,0,0,16'hFFFF});
        @(negedge clk);
        v = '0; v.idv = 1; v.pc = 32'h328; v.reg1 = 32'h5000; v.src1 = 5'd1; v.dest = 5'd7;
        v.imm = 32'h14; v.cmd = 4'd1; v.mr = 1; v.wb = 1; v.is_imm = 1;
        apply(v);
        step("lw5", '{1,32'h328,32'h5000,32'h14,32'h0,5'd7,4'd1,1,0,1,16'hFFFF});
        @(negedge clk);
        v = '0; v.idv = 1; v.pc = 32'h32C; v.src1 = 5'd7; v.dest = 5'd14; v.cmd = 4'd2; v.wb = 1;
        apply(v);
        #1 cmp("sat.stall", 32'(stall_out), 32'd1);
        step("sat_hold", '{0,32'h328,32'h5000,32'h14,32'h0,5'd7,4'd0,0,0,0,16'hFFFF});

        // Asynchronous reset between edges, then a normal load after release.
        @(negedge clk);
        v = '0; v.idv = 1; v.pc = 32'h400; v.reg1 = 32'h77; v.src1 = 5'd1; v.dest = 5'd3;
        v.cmd = 4'd9; v.wb = 1;
        apply(v);
        step("pre_rst", '{1,32'h400,32'h77,32'h0,32'h0,5'd3,4'd9,0,0,1,16'hFFFF});
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", '{1,32'h400,32'h77,32'h0,32'h0,5'd3,4'd9,0,0,1,16'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
